// File: rtl/axi_resp_pkg.sv
// Shared types for the AXI read responder: FSM states, queued request record,
// bus widths and the fixed OKAY response code.
package axi_resp_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  // Widest ARID the request record can carry; instances use ID_WIDTH <= ID_MAX_W.
  localparam int ID_MAX_W = 8;
  localparam logic [1:0] RRESP_OKAY = 2'b00;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} resp_state_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
  } rd_req_t;
endpackage

// File: rtl/axi_read_responder_if.sv
// AR/R channel bundle between a read master and the read responder.
interface axi_read_responder_if #(
  parameter int ID_WIDTH = 4
) ();
  import axi_resp_pkg::*;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  arid, araddr, arlen, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output arid, araddr, arlen, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/req_fifo.sv
// Synchronous FIFO of read requests; pointers carry an extra wrap bit so
// full and empty are told apart without a separate counter.
module req_fifo
  import axi_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  rd_req_t                i_din,
  output rd_req_t                o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  rd_req_t     r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push_ok;
  logic        w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/axi_read_responder.sv
// AXI INCR-burst read slave backed by a word-addressed memory: queues requests,
// waits LATENCY cycles, then streams ARLEN+1 beats in order.
module axi_read_responder
  import axi_resp_pkg::*;
#(
  parameter int MEM_AW    = 12,
  parameter int LATENCY   = 4,
  parameter int REQ_DEPTH = 4,
  parameter int ID_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_read_responder_if.slave   bus,
  input  logic                  dbg_we,
  input  logic [MEM_AW-1:0]     dbg_waddr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [31:0]           req_count,
  output logic [31:0]           beat_count
);
  localparam int CNT_W = $clog2(REQ_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] r_mem [2**MEM_AW];
  resp_state_t           r_state, w_state_n;
  logic [7:0]            r_wait_cnt, w_wait_cnt_n;
  logic [7:0]            r_beats_left, w_beats_left_n;
  logic [MEM_AW-1:0]     r_cur_idx, w_cur_idx_n;
  logic [ID_WIDTH-1:0]   r_cur_id, w_cur_id_n;
  logic                  r_rvalid, w_rvalid_n;
  logic                  r_rlast, w_rlast_n;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_n;
  logic                  r_arready;
  logic [31:0]           r_req_count, r_beat_count;

  logic                  w_push, w_pop, w_start, w_r_hs;
  logic                  w_full, w_empty;
  logic [CNT_W-1:0]      w_count, w_count_n;
  rd_req_t               w_push_req, w_head;
  logic [MEM_AW-1:0]     w_head_idx, w_next_idx;
  logic                  w_unused;

  assign w_push     = bus.arvalid && r_arready;
  assign w_r_hs     = r_rvalid && bus.rready;
  assign w_push_req = {ID_MAX_W'(bus.arid), bus.araddr, bus.arlen};
  assign w_head_idx = w_head.addr[MEM_AW+1:2];
  assign w_next_idx = r_cur_idx + MEM_AW'(1);
  assign w_count_n  = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_unused   = ^{w_head, w_full};

  req_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_req),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_n      = r_state;
    w_wait_cnt_n   = r_wait_cnt;
    w_beats_left_n = r_beats_left;
    w_cur_idx_n    = r_cur_idx;
    w_cur_id_n     = r_cur_id;
    w_rvalid_n     = r_rvalid;
    w_rlast_n      = r_rlast;
    w_rdata_n      = r_rdata;
    w_start        = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: w_start = 1'b1;
      WAIT: begin
        w_wait_cnt_n = r_wait_cnt - 8'd1;
        if (r_wait_cnt == 8'd1) begin
          w_state_n  = BURST;
          w_rvalid_n = 1'b1;
          w_rdata_n  = r_mem[r_cur_idx];
          w_rlast_n  = (r_beats_left == 8'd0);
        end
      end
      BURST: begin
        if (bus.rready) begin
          if (r_rlast) begin
            // Last beat taken: fall through to the idle evaluation this same edge.
            w_rvalid_n = 1'b0;
            w_rlast_n  = 1'b0;
            w_state_n  = IDLE;
            w_start    = 1'b1;
          end else begin
            w_cur_idx_n    = w_next_idx;
            w_beats_left_n = r_beats_left - 8'd1;
            w_rdata_n      = r_mem[w_next_idx];
            w_rlast_n      = (r_beats_left == 8'd1);
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
    if (w_start && !w_empty) begin
      w_pop          = 1'b1;
      w_cur_id_n     = w_head.id[ID_WIDTH-1:0];
      w_cur_idx_n    = w_head_idx;
      w_beats_left_n = w_head.len;
      if (LATENCY == 0) begin
        w_state_n  = BURST;
        w_rvalid_n = 1'b1;
        w_rdata_n  = r_mem[w_head_idx];
        w_rlast_n  = (w_head.len == 8'd0);
      end else begin
        w_state_n    = WAIT;
        w_wait_cnt_n = 8'(LATENCY);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wait_cnt   <= '0;
      r_cur_id     <= '0;
      r_rvalid     <= 1'b0;
      r_rlast      <= 1'b0;
      r_rdata      <= '0;
      r_arready    <= 1'b0;
      r_req_count  <= '0;
      r_beat_count <= '0;
    end else begin
      r_state      <= w_state_n;
      r_wait_cnt   <= w_wait_cnt_n;
      r_cur_id     <= w_cur_id_n;
      r_rvalid     <= w_rvalid_n;
      r_rlast      <= w_rlast_n;
      r_rdata      <= w_rdata_n;
      // Registered from the post-edge occupancy, so a full queue refuses even when popped.
      r_arready    <= (w_count_n != CNT_W'(REQ_DEPTH));
      r_req_count  <= r_req_count + 32'(w_push);
      r_beat_count <= r_beat_count + 32'(w_r_hs);
    end
  end

  always_ff @(posedge clk) begin
    r_cur_idx    <= w_cur_idx_n;
    r_beats_left <= w_beats_left_n;
  end

  always_ff @(posedge clk) begin
    if (dbg_we) r_mem[dbg_waddr] <= dbg_wdata;
  end

  assign bus.arready = r_arready;
  assign bus.rid     = r_cur_id;
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = RRESP_OKAY;
  assign bus.rlast   = r_rlast;
  assign bus.rvalid  = r_rvalid;
  assign req_count   = r_req_count;
  assign beat_count  = r_beat_count;
endmodule

// File: tb/tb_axi_read_responder.sv
// Scoreboard bench for axi_read_responder: expected beats come from a plain
// memory array model and are checked by an independent R-channel monitor.
module tb_axi_read_responder;
  import axi_resp_pkg::*;

  localparam int MEM_AW    = 12;
  localparam int LATENCY   = 4;
  localparam int REQ_DEPTH = 4;
  localparam int ID_WIDTH  = 4;
  localparam int MEM_WORDS = 1 << MEM_AW;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  dbg_we;
  logic [MEM_AW-1:0]     dbg_waddr;
  logic [DATA_WIDTH-1:0] dbg_wdata;
  logic [31:0]           req_count;
  logic [31:0]           beat_count;

  axi_read_responder_if #(.ID_WIDTH(ID_WIDTH)) bus ();

  axi_read_responder #(
    .MEM_AW(MEM_AW), .LATENCY(LATENCY), .REQ_DEPTH(REQ_DEPTH), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_we     (dbg_we),
    .dbg_waddr  (dbg_waddr),
    .dbg_wdata  (dbg_wdata),
    .req_count  (req_count),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         data;
    logic                last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] ref_mem [MEM_WORDS];
  int          errors = 0;
  int          checks = 0;
  int          beats_seen = 0;
  int          req_since_rst = 0;
  int          beats_since_rst = 0;
  int          rr_mode = 0;
  bit          gap_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_expected(input logic [ID_WIDTH-1:0] id,
                                        input logic [31:0] addr, input logic [7:0] len);
    int    idx;
    beat_t e;
    idx = int'(addr >> 2) % MEM_WORDS;
    for (int b = 0; b <= int'(len); b++) begin
      e.id   = id;
      e.data = ref_mem[(idx + b) % MEM_WORDS];
      e.last = (b == int'(len));
      exp_q.push_back(e);
    end
  endfunction

  // R-channel monitor: samples on the falling edge, between driven updates.
  initial begin : monitor
    beat_t               e;
    bit                  st_valid;
    logic [31:0]         st_data;
    logic [ID_WIDTH-1:0] st_id;
    logic                st_last;
    int                  gap_run;
    st_valid = 1'b0;
    gap_run  = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        st_valid = 1'b0;
        gap_run  = -1;
      end else begin
        if (st_valid) begin
          check("stall_rvalid", 32'(bus.rvalid), 32'(1));
          check("stall_rdata", bus.rdata, st_data);
          check("stall_rid_rlast", 32'({bus.rid, bus.rlast}), 32'({st_id, st_last}));
        end
        if (gap_run >= 0) begin
          if (bus.rvalid) begin
            check("burst_gap", 32'(gap_run), 32'(LATENCY));
            gap_run = -1;
          end else if (gap_run > 300) begin
            check("burst_gap_timeout", 32'(gap_run), 32'(LATENCY));
            gap_run = -1;
          end else begin
            gap_run++;
          end
        end
        if (bus.rvalid && bus.rready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got rid=%h rdata=%h, no beat expected", bus.rid, bus.rdata);
          end else begin
            e = exp_q.pop_front();
            check("rid", 32'(bus.rid), 32'(e.id));
            check("rdata", bus.rdata, e.data);
            check("rlast", 32'(bus.rlast), 32'(e.last));
            check("rresp", 32'(bus.rresp), 32'(0));
            beats_seen++;
            beats_since_rst++;
            if (e.last && gap_chk && exp_q.size() > 0) gap_run = 0;
          end
        end
        st_valid = bus.rvalid && !bus.rready;
        st_data  = bus.rdata;
        st_id    = bus.rid;
        st_last  = bus.rlast;
      end
    end
  end

  initial begin : rready_drv
    int ph;
    ph = 0;
    bus.rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = 1'($urandom_range(0, 1));
        2:       begin bus.rready = (ph % 3 == 0); ph++; end
        default: bus.rready = 1'b0;
      endcase
    end
  end

  task automatic mem_write(input int idx, input logic [31:0] d);
    dbg_we    = 1'b1;
    dbg_waddr = MEM_AW'(idx);
    dbg_wdata = d;
    @(posedge clk);
    #1;
    dbg_we = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic send_ar(input logic [ID_WIDTH-1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, output int wait_cyc);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    bus.arvalid = 1'b1;
    bus.arid    = id;
    bus.araddr  = addr;
    bus.arlen   = len;
    while (!done) begin
      @(negedge clk);
      if (bus.arready) begin
        push_expected(id, addr, len);
        req_since_rst++;
        done = 1'b1;
      end else if (n >= 500) begin
        checks++;
        errors++;
        $display("FAIL ar_timeout: got no arready after %0d cycles, required acceptance", n);
        done = 1'b1;
      end else begin
        n++;
      end
      @(posedge clk);
      #1;
    end
    bus.arvalid = 1'b0;
    wait_cyc = n;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string name);
    check({name, "_req_count"}, req_count, 32'(req_since_rst));
    check({name, "_beat_count"}, beat_count, 32'(beats_since_rst));
  endtask

  initial begin : stimulus
    int w;
    int n;
    int base;
    rst         = 1'b1;
    dbg_we      = 1'b0;
    dbg_waddr   = '0;
    dbg_wdata   = '0;
    bus.arvalid = 1'b0;
    bus.arid    = '0;
    bus.araddr  = '0;
    bus.arlen   = '0;
    @(posedge clk);
    #1;
    check("rst_arready", 32'(bus.arready), 32'(0));
    check("rst_rvalid", 32'(bus.rvalid), 32'(0));
    check("rst_rlast_rid", 32'({bus.rlast, bus.rid}), 32'(0));
    check("rst_rdata", bus.rdata, 32'(0));
    check("rst_rresp", 32'(bus.rresp), 32'(0));
    check("rst_req_count", req_count, 32'(0));
    check("rst_beat_count", beat_count, 32'(0));

    // Backing store survives reset, so preload while reset is held.
    for (int i = 0; i < MEM_WORDS; i++) mem_write(i, $urandom);
    for (int i = 0; i < 4; i++) mem_write(16 + i, 32'hA0 + 32'(i));
    mem_write(MEM_WORDS - 1, 32'h11);
    mem_write(0, 32'h22);
    mem_write(8, 32'h0BAD_0008);
    check("rst_hold_arready", 32'(bus.arready), 32'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("arready_after_rst", 32'(bus.arready), 32'(1));

    // Basic burst with first-beat latency
    rr_mode = 0;
    @(posedge clk);
    #1;
    send_ar(4'd5, 32'h40, 8'd3, w);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (bus.rvalid) break;
      n++;
    end
    check("first_beat_latency", 32'(n), 32'(LATENCY + 1));
    drain("basic");
    check("basic_beat_count", beat_count, 32'(4));
    check_counts("basic");

    // Same burst under a 1,0,0 rready pattern
    rr_mode = 2;
    send_ar(4'd6, 32'h40, 8'd3, w);
    drain("stall");
    check_counts("stall");

    // Fill the queue behind a stalled burst
    rr_mode = 3;
    @(posedge clk);
    #1;
    send_ar(4'd1, 32'h40, 8'd2, w);
    n = 0;
    while (!bus.rvalid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < REQ_DEPTH; i++) begin
      send_ar(4'(2 + i), $urandom, 8'($urandom_range(0, 3)), w);
      check("b2b_accept_wait", 32'(w), 32'(0));
    end
    check("arready_when_full", 32'(bus.arready), 32'(0));
    gap_chk = 1'b1;
    rr_mode = 0;
    send_ar(4'd7, $urandom, 8'd1, w);
    check("full_push_waited", 32'(w > 0), 32'(1));
    drain("b2b");
    gap_chk = 1'b0;
    check_counts("b2b");

    // Index wrap-around, with ignored low and high address bits
    rr_mode = 1;
    send_ar(4'd8, 32'h3FFC, 8'd1, w);
    send_ar(4'd9, 32'hABCD_3FFE, 8'd1, w);
    drain("wrap");
    check_counts("wrap");

    // Reset in the middle of a long burst
    rr_mode = 0;
    @(posedge clk);
    #1;
    base = beats_seen;
    send_ar(4'd10, 32'h40, 8'd7, w);
    n = 0;
    while (beats_seen < base + 1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst = 1'b1;
    exp_q.delete();
    req_since_rst   = 0;
    beats_since_rst = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_rvalid", 32'(bus.rvalid), 32'(0));
    check("midrst_arready", 32'(bus.arready), 32'(0));
    check_counts("midrst");
    @(posedge clk);
    #1;
    check("midrst_arready_back", 32'(bus.arready), 32'(1));
    send_ar(4'd11, 32'h40, 8'd3, w);
    drain("post_rst");
    check_counts("post_rst");

    // Debug write on the same edge the beat is loaded: old word is returned
    send_ar(4'd12, 32'h20, 8'd0, w);
    repeat (LATENCY) @(posedge clk);
    #1;
    mem_write(8, 32'hDEAD);
    drain("hazard_old");
    send_ar(4'd13, 32'h20, 8'd0, w);
    drain("hazard_new");

    // Randomized traffic with random backpressure
    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send_ar(4'($urandom), $urandom, 8'($urandom_range(0, 9)), w);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain("random");
    check_counts("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/axi_read_responder.md
Name: axi_read_responder

Overview:
- AXI read slave and memory model. It answers the read-address/read-data master used by the instruction-side stream buffer and caches.
- Accepts INCR burst read requests into a small request queue and waits a programmable access latency. It then streams ARLEN+1 data beats from an internal word-addressed backing store.
- Used as the memory end in simulation and FPGA builds. A debug write port lets the bench preload memory contents.

Parameters:
- MEM_AW, 12: log2 of backing-store depth in 32-bit words (4096 words).
- LATENCY, 4: wait cycles between request dequeue and first data beat (0..255).
- REQ_DEPTH, 4: request queue entries, power of two, minimum 2.
- ID_WIDTH, 4: width of ARID/RID.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-high.
- arid, in, ID_WIDTH: request ID.
- araddr, in, `ADDR_WIDTH: byte address of the first beat.
- arlen, in, 8: beats minus one.
- arvalid, in, 1: request valid.
- arready, out, 1: request accepted when high together with arvalid.
- rid, out, ID_WIDTH: ID of the current burst.
- rdata, out, `DATA_WIDTH: beat data.
- rresp, out, 2: always 2'b00 (OKAY).
- rlast, out, 1: final beat of the burst.
- rvalid, out, 1: beat valid.
- rready, in, 1: master accepts the beat.
- dbg_we, in, 1: backing-store write enable.
- dbg_waddr, in, MEM_AW: word index for the debug write.
- dbg_wdata, in, `DATA_WIDTH: debug write data.
- req_count, out, 32: accepted AR handshakes since reset.
- beat_count, out, 32: completed R handshakes since reset.

Behaviour:
- Reset values: arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, req_count=0, beat_count=0.
  - Queue is flushed; FSM is IDLE. Backing-store contents are retained.
  - Reset mid-burst abandons the burst silently.
- arready is registered and equals !queue_full from the cycle after reset. Full-cycle push is never accepted, even if a pop happens on the same edge; there is no combinational arready path.
- AR handshake on edge E pushes {arid, araddr, arlen} into the queue.
- Word index = araddr[MEM_AW+1:2]. Address bits [1:0] and upper bits are ignored.
- FSM states are IDLE, WAIT and BURST.
- IDLE, queue non-empty: pop the head and load cur_id, cur_idx, beats_left=len.
  - If LATENCY==0: go to BURST with rvalid<=1, rdata<=mem[cur_idx], rlast<=(len==0).
  - Otherwise: wait_cnt<=LATENCY and go to WAIT.
- WAIT: decrement wait_cnt each edge. On the edge where wait_cnt==1, enter BURST, loading rvalid, rdata and rlast as above.
- Timing: for a request arriving with FSM idle and queue empty, the first rvalid is high in the cycle after edge E+LATENCY+1.
- BURST:
  - rid, rdata and rlast hold stable while rvalid && !rready.
  - On a non-last handshake: cur_idx increments mod 2^MEM_AW (wraps 4095->0), beats_left decrements, and rdata<=mem[next idx] with rvalid staying high (no bubble).
  - On the rlast handshake: rvalid<=0, and the FSM performs the IDLE evaluation on the same edge. A queued request therefore starts WAIT (or BURST if LATENCY==0) with no extra idle cycle.
- Memory read is combinational from the array into the registered rdata.
- Debug write on edge W is visible to beat loads on later edges. A load on edge W to the same index gets the old word.
- req_count increments on each AR handshake; beat_count on each R handshake. Both wrap at 2^32.
- In-order responses only; no interleaving; RRESP is never an error.

Decomposition:
- Package axi_resp_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, BURST} resp_state_t;
  - typedef struct packed {id, addr, len} rd_req_t;
  - localparam RRESP_OKAY=2'b00.
- Sub-module req_fifo: synchronous FIFO of rd_req_t with parameter DEPTH, push/pop/full/empty and count. It uses pointer wrap with an extra MSB and the same active-high synchronous reset.
- FSM, backing store array and counters live in the top.

Test Plan:
- Preload mem[0x10..0x13]=0xA0..0xA3; LATENCY=4; AR araddr=0x40, arlen=3, arid=5, rready=1 -> rvalid first high 5 cycles after the AR edge. Expect 4 consecutive beats 0xA0..0xA3, rid=5, rlast only on 0xA3, beat_count=4.
- Same burst with rready toggling 1,0,0,1,... -> rdata/rlast stable during stalls; the beat sequence is unchanged with no duplicates or skips.
- Push 5 requests back-to-back, arvalid held, while the first burst is stalled -> arready drops after 4 accepts and reasserts after a pop. Responses come out in ID order, and with LATENCY=0 there is no gap between bursts.
- araddr=0x3FFC (idx 4095), arlen=1, mem[4095]=0x11, mem[0]=0x22 -> beats 0x11, 0x22 (wrap-around).
- Assert rst during the second beat of an arlen=7 burst -> next cycle rvalid=0, arready=0, counters=0. The cycle after, arready=1; a new request returns correct preloaded data.
- Debug write mem[8]=0xDEAD on the same edge that beat idx 8 is loaded -> beat shows the old value. A subsequent burst shows 0xDEAD.
